alu_op_driver: RTL and testbench

// Initiator for the 8-bit registered ALU (sel 0=ADD, 1=SUB, 2=MUL, 3=DIV; one-cycle registered result, carry from add).
// - Accepts operation requests on a valid/ready port and screens illegal requests.
// - Drives operands and select to the ALU, waits out its register latency, captures the result.
// - Returns the result with carry, error and tag on a valid/ready response port. One operation in flight.

---
 rtl/alu_op_driver.sv | 130 +++++++++++++
 tb/tb_alu_op_driver.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_driver.sv
// Request/response front end for the 8-bit registered ALU: screens requests,
// drives one operation at a time, and returns the captured result with its tag.
module alu_op_driver #(
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned TAG_W    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [3:0]       req_sel,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic [15:0]      op_count,
  output logic [15:0]      err_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_DIV = SEL_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t              state;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                legal_c;

  // Only ADD/SUB/MUL/DIV with a non-zero divisor reach the ALU.
  assign legal_c = (req_sel <= SEL_DIV) && !((req_sel == SEL_DIV) && (req_b == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      op_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rsp_tag   <= req_tag;
            if (legal_c) begin
              alu_a    <= req_a;
              alu_b    <= req_b;
              alu_sel  <= req_sel;
              wait_cnt <= WCNT_W'(WAIT_CYC - 1);
              state    <= S_DRIVE;
            end else begin
              rsp_data  <= '0;
              rsp_carry <= 1'b0;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end
          end
        end

        // Operands held stable while the ALU register settles.
        S_DRIVE: begin
          if (wait_cnt == '0) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - WCNT_W'(1);
          end
        end

        S_CAPTURE: begin
          rsp_data  <= alu_out;
          rsp_carry <= (alu_sel == SEL_ADD) ? alu_carry : 1'b0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end

        // Rejected requests enter RESP with valid low and raise it one cycle later.
        S_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + CNT_W'(1);
            err_count <= err_count + CNT_W'(rsp_err);
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  logic unused_c;
  assign unused_c = ^{DATA_W[0]};

endmodule

// File: tb/tb_alu_op_driver.sv
// Scoreboard bench for alu_op_driver with a behavioural registered ALU attached.
module tb_alu_op_driver;

  localparam int unsigned WAIT_CYC = 1;
  localparam int unsigned TAG_W    = 4;

  typedef struct packed {
    logic [7:0]       data;
    logic             carry;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic             clock;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [3:0]       req_sel;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_carry;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_sel;
  logic [7:0]       alu_out;
  logic             alu_carry;
  logic [15:0]      op_count;
  logic [15:0]      err_count;

  int tests;
  int fails;
  rsp_t sb[$];

  alu_op_driver #(.WAIT_CYC(WAIT_CYC), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .op_count(op_count), .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered ALU stand-in: result appears one clock after the operands.
  always_ff @(posedge clock) begin
    logic [8:0] sum;
    logic [15:0] prod;
    sum  = {1'b0, alu_a} + {1'b0, alu_b};
    prod = alu_a * alu_b;
    alu_carry <= sum[8];
    case (alu_sel)
      4'd0:    alu_out <= sum[7:0];
      4'd1:    alu_out <= alu_a - alu_b;
      4'd2:    alu_out <= prod[7:0];
      4'd3:    alu_out <= (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
      default: alu_out <= 8'h00;
    endcase
  end

  function automatic rsp_t expect_rsp(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] sel, input logic [TAG_W-1:0] tag);
    rsp_t r;
    logic [8:0] s;
    logic [15:0] p;
    r = '0;
    r.tag = tag;
    s = {1'b0, a} + {1'b0, b};
    p = a * b;
    if (sel > 4'd3 || (sel == 4'd3 && b == 8'h00)) begin
      r.err = 1'b1;
    end else begin
      case (sel)
        4'd0: begin r.data = s[7:0]; r.carry = s[8]; end
        4'd1: r.data = a - b;
        4'd2: r.data = p[7:0];
        default: r.data = a / b;
      endcase
    end
    return r;
  endfunction

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clock) begin
    rsp_t e;
    rsp_t o;
    if (reset_n) begin
      if (req_valid && req_ready)
        sb.push_back(expect_rsp(req_a, req_b, req_sel, req_tag));
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_spurious: response data=%h err=%b tag=%h with no request outstanding",
                   rsp_data, rsp_err, rsp_tag);
        end else begin
          e = sb.pop_front();
          o = '{data: rsp_data, carry: rsp_carry, err: rsp_err, tag: rsp_tag};
          if (o !== e) begin
            fails++;
            $display("FAIL sb_rsp: got data=%h carry=%b err=%b tag=%h, want data=%h carry=%b err=%b tag=%h",
                     o.data, o.carry, o.err, o.tag, e.data, e.carry, e.err, e.tag);
          end
        end
      end
    end
  end

  // Present one request from IDLE; lat = clock edges from accept edge to rsp_valid high.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                       input logic [TAG_W-1:0] tag, output int lat);
    int w;
    w = 0;
    lat = 0;
    req_a = a; req_b = b; req_sel = sel; req_tag = tag;
    req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (w >= 20) begin
      lat = -1;
    end else begin
      while (!rsp_valid && lat < 20) begin
        @(posedge clock); #1;
        lat++;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; req_tag = '0;
    rsp_ready = 1'b1;
    #12;
    tests++;
    if ({rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_tag, alu_a, alu_b, alu_sel,
         op_count, err_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rsp_valid=%b data=%h alu=%h/%h/%h op=%h err=%h, want all 0",
               rsp_valid, rsp_data, alu_a, alu_b, alu_sel, op_count, err_count);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_add();
    int lat;
    issue(8'hC8, 8'h64, 4'h0, 4'h3, lat);
    tests++;
    if (lat != WAIT_CYC + 1) begin
      fails++;
      $display("FAIL add_latency: got %0d want %0d", lat, WAIT_CYC + 1);
    end
    tests++;
    if ({rsp_data, rsp_carry, rsp_err, rsp_tag} !== {8'h2C, 1'b1, 1'b0, 4'h3}) begin
      fails++;
      $display("FAIL add_result: got data=%h carry=%b err=%b tag=%h want 2c/1/0/3",
               rsp_data, rsp_carry, rsp_err, rsp_tag);
    end
    next_cycle();
  endtask

  task automatic test_arith();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [3:0] ts [3];
    int lat;
    ta = '{8'h05, 8'h10, 8'hFF};
    tb = '{8'h0A, 8'h11, 8'h10};
    ts = '{4'h1, 4'h2, 4'h3};
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], ts[i], 4'(i + 8), lat);
      tests++;
      if (lat != WAIT_CYC + 1 || rsp_carry !== 1'b0) begin
        fails++;
        $display("FAIL arith_op%0d: latency=%0d carry=%b want latency=%0d carry=0",
                 ts[i], lat, rsp_carry, WAIT_CYC + 1);
      end
      next_cycle();
    end
  endtask

  task automatic test_div_zero();
    logic [19:0] alu_before;
    int lat;
    alu_before = {alu_a, alu_b, alu_sel};
    issue(8'h40, 8'h00, 4'h3, 4'h5, lat);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL div0_latency: got %0d want 1", lat);
    end
    tests++;
    if (rsp_err !== 1'b1 || rsp_data !== 8'h00 || {alu_a, alu_b, alu_sel} !== alu_before) begin
      fails++;
      $display("FAIL div0_reject: err=%b data=%h alu=%h want err=1 data=00 alu=%h",
               rsp_err, rsp_data, {alu_a, alu_b, alu_sel}, alu_before);
    end
    next_cycle();
    tests++;
    if (err_count !== 16'd1) begin
      fails++;
      $display("FAIL div0_err_count: got %0d want 1", err_count);
    end
  endtask

  task automatic test_illegal_sel();
    logic [19:0] alu_before;
    int lat;
    alu_before = {alu_a, alu_b, alu_sel};
    issue(8'h12, 8'h34, 4'h7, 4'hA, lat);
    tests++;
    if (lat != 1 || rsp_err !== 1'b1 || rsp_data !== 8'h00 ||
        {alu_a, alu_b, alu_sel} !== alu_before) begin
      fails++;
      $display("FAIL badsel_reject: lat=%0d err=%b data=%h alu=%h want 1/1/00/%h",
               lat, rsp_err, rsp_data, {alu_a, alu_b, alu_sel}, alu_before);
    end
    next_cycle();
    issue(8'hFF, 8'h01, 4'h0, 4'hB, lat);
    tests++;
    if (lat != WAIT_CYC + 1 || rsp_data !== 8'h00 || rsp_carry !== 1'b1 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL add_wrap: lat=%0d data=%h carry=%b err=%b want %0d/00/1/0",
               lat, rsp_data, rsp_carry, rsp_err, WAIT_CYC + 1);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    rsp_t held;
    logic [15:0] cnt0;
    int lat;
    rsp_ready = 1'b0;
    issue(8'h33, 8'h22, 4'h1, 4'hC, lat);
    held = '{data: rsp_data, carry: rsp_carry, err: rsp_err, tag: rsp_tag};
    cnt0 = op_count;
    // A competing request stays asserted while the response is stalled.
    req_a = 8'h01; req_b = 8'h01; req_sel = 4'h0; req_tag = 4'hD;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || op_count !== cnt0 ||
          {rsp_data, rsp_carry, rsp_err, rsp_tag} !== held) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%b ready=%b op=%0d rsp=%h want 1/0/%0d/%h",
                 i, rsp_valid, req_ready, op_count, {rsp_data, rsp_carry, rsp_err, rsp_tag},
                 cnt0, held);
      end
    end
    rsp_ready = 1'b1;
    next_cycle();
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || op_count !== cnt0 + 16'd1) begin
      fails++;
      $display("FAIL stall_release: req_ready=%b rsp_valid=%b op=%0d want 1/0/%0d",
               req_ready, rsp_valid, op_count, cnt0 + 16'd1);
    end
    req_valid = 1'b0;
    next_cycle();
    tests++;
    if (op_count !== cnt0 + 16'd1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_count_once: op=%0d rsp_valid=%b want %0d/0",
               op_count, rsp_valid, cnt0 + 16'd1);
    end
  endtask

  task automatic test_reset_in_drive();
    int lat;
    int seen;
    req_a = 8'h10; req_b = 8'h20; req_sel = 4'h0; req_tag = 4'h6;
    req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    sb.delete();
    tests++;
    if ({rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_tag, alu_a, alu_b, alu_sel,
         op_count, err_count} !== '0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL drive_reset: req_ready=%b rsp_valid=%b alu=%h/%h/%h op=%0d err=%0d want 1 and all 0",
               req_ready, rsp_valid, alu_a, alu_b, alu_sel, op_count, err_count);
    end
    next_cycle();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (rsp_valid !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0 || op_count !== 16'd0 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL drive_reset_idle: rsp_valid cycles=%0d op=%0d err=%0d want 0/0/0",
               seen, op_count, err_count);
    end
    issue(8'h01, 8'h02, 4'h0, 4'h9, lat);
    tests++;
    if (lat != WAIT_CYC + 1 || rsp_data !== 8'h03 || rsp_tag !== 4'h9) begin
      fails++;
      $display("FAIL post_reset_add: lat=%0d data=%h tag=%h want %0d/03/9",
               lat, rsp_data, rsp_tag, WAIT_CYC + 1);
    end
    next_cycle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add();
    test_arith();
    test_div_zero();
    test_illegal_sel();
    test_backpressure();
    test_reset_in_drive();
    repeat (2) next_cycle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
